// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry and parity helper.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int UART_SAMPLING   = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // Even parity of a zero-extended word: zero padding does not change the XOR.
    function automatic logic even_parity(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver bus: line-side inputs (rx, b_tick) plus the byte/strobe outputs toward the parser.
interface uart_rx_if import uart_pkg::*; #(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
);
    logic                  b_tick;
    logic                  rx;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_done;
    logic                  rx_busy;
    logic                  frame_err;
    logic                  parity_err;

    modport master (
        input  b_tick, rx,
        output rx_data, rx_done, rx_busy, frame_err, parity_err
    );

    modport slave (
        output b_tick, rx,
        input  rx_data, rx_done, rx_busy, frame_err, parity_err
    );
endinterface

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for an async level input; resets to 1 so an idle-high line is not seen as a start.
module uart_sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta_r;
    logic sync_r;

    // Synchronizer chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;
endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 with parity_err.
module uart_rx import uart_pkg::*; #(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int SAMPLING   = UART_SAMPLING
) (
    input logic       clk,
    input logic       reset,
    uart_rx_if.master bus
);
    localparam int TW = $clog2(SAMPLING);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [TW-1:0] TICK_MID = TW'(SAMPLING / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(SAMPLING - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
`ifdef UART_RX_PARITY_EN
    localparam rx_state_e AFTER_DATA = PARITY;
`else
    localparam rx_state_e AFTER_DATA = STOP;
`endif

    logic                  rx_s;
    rx_state_e             state_r, state_nxt_s;
    logic [TW-1:0]         tick_cnt_r, tick_nxt_s;
    logic [BW-1:0]         bit_cnt_r, bit_nxt_s;
    logic [DATA_WIDTH-1:0] shift_r, shift_nxt_s;
    logic [DATA_WIDTH-1:0] rx_data_r, data_nxt_s;
    logic                  rx_done_r, done_nxt_s;
    logic                  rx_busy_r;
    logic                  frame_err_r, ferr_nxt_s;
    logic                  par_ok_s;
`ifdef UART_RX_PARITY_EN
    logic                  par_bit_r, par_nxt_s;
    logic                  parity_err_r, perr_nxt_s;
`endif

    uart_sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.rx),
        .q     (rx_s)
    );

    // Next-state, datapath and strobe decode.
    always_comb begin
        state_nxt_s = state_r;
        tick_nxt_s  = tick_cnt_r;
        bit_nxt_s   = bit_cnt_r;
        shift_nxt_s = shift_r;
        data_nxt_s  = rx_data_r;
        done_nxt_s  = 1'b0;
        ferr_nxt_s  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_nxt_s   = par_bit_r;
        perr_nxt_s  = 1'b0;
        par_ok_s    = (even_parity(32'(shift_r)) == par_bit_r);
`else
        par_ok_s    = 1'b1;
`endif
        case (state_r)
            IDLE: begin
                if (!rx_s) begin
                    tick_nxt_s  = '0;
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (bus.b_tick && (tick_cnt_r == TICK_MID)) begin
                    tick_nxt_s = '0;
                    if (!rx_s) begin
                        bit_nxt_s   = '0;
                        state_nxt_s = DATA;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else if (bus.b_tick) begin
                    tick_nxt_s = tick_cnt_r + 1'b1;
                end else begin
                    tick_nxt_s = tick_cnt_r;
                end
            end
            DATA: begin
                if (bus.b_tick && (tick_cnt_r == TICK_END)) begin
                    tick_nxt_s  = '0;
                    shift_nxt_s = {rx_s, shift_r[DATA_WIDTH-1:1]};
                    if (bit_cnt_r == BIT_LAST) begin
                        state_nxt_s = AFTER_DATA;
                    end else begin
                        bit_nxt_s = bit_cnt_r + 1'b1;
                    end
                end else if (bus.b_tick) begin
                    tick_nxt_s = tick_cnt_r + 1'b1;
                end else begin
                    tick_nxt_s = tick_cnt_r;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bus.b_tick && (tick_cnt_r == TICK_END)) begin
                    tick_nxt_s  = '0;
                    par_nxt_s   = rx_s;
                    state_nxt_s = STOP;
                end else if (bus.b_tick) begin
                    tick_nxt_s = tick_cnt_r + 1'b1;
                end else begin
                    tick_nxt_s = tick_cnt_r;
                end
            end
`endif
            STOP: begin
                // Return to IDLE at mid-stop so a following start edge is caught half a bit early.
                if (bus.b_tick && (tick_cnt_r == TICK_END)) begin
                    tick_nxt_s  = '0;
                    state_nxt_s = IDLE;
                    done_nxt_s  = rx_s && par_ok_s;
                    ferr_nxt_s  = !rx_s;
`ifdef UART_RX_PARITY_EN
                    perr_nxt_s  = !par_ok_s;
`endif
                    if (rx_s && par_ok_s) begin
                        data_nxt_s = shift_r;
                    end else begin
                        data_nxt_s = rx_data_r;
                    end
                end else if (bus.b_tick) begin
                    tick_nxt_s = tick_cnt_r + 1'b1;
                end else begin
                    tick_nxt_s = tick_cnt_r;
                end
            end
            default: begin
                tick_nxt_s  = '0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered output update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            tick_cnt_r   <= '0;
            bit_cnt_r    <= '0;
            shift_r      <= '0;
            rx_data_r    <= '0;
            rx_done_r    <= 1'b0;
            rx_busy_r    <= 1'b0;
            frame_err_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_r    <= 1'b0;
            parity_err_r <= 1'b0;
`endif
        end else begin
            state_r      <= state_nxt_s;
            tick_cnt_r   <= tick_nxt_s;
            bit_cnt_r    <= bit_nxt_s;
            shift_r      <= shift_nxt_s;
            rx_data_r    <= data_nxt_s;
            rx_done_r    <= done_nxt_s;
            rx_busy_r    <= (state_nxt_s != IDLE);
            frame_err_r  <= ferr_nxt_s;
`ifdef UART_RX_PARITY_EN
            par_bit_r    <= par_nxt_s;
            parity_err_r <= perr_nxt_s;
`endif
        end
    end

    assign bus.rx_data   = rx_data_r;
    assign bus.rx_done   = rx_done_r;
    assign bus.rx_busy   = rx_busy_r;
    assign bus.frame_err = frame_err_r;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_r;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx: a TX line model drives frames, a frame-level model predicts outcomes.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int SAMPLING = 16;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = SAMPLING * TICK_DIV;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int LAT_NOM = 2 + (SAMPLING / 2 + 8 * SAMPLING + PAR_BITS * SAMPLING + SAMPLING) * TICK_DIV;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic [1:0] tick_div = 2'd0;

    uart_rx_if bus ();

    uart_rx #(.DATA_WIDTH(8), .SAMPLING(SAMPLING)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tick_div   <= tick_div + 2'd1;
        bus.b_tick <= (tick_div == 2'd3);
    end

    // Event monitor, sampled on the inactive edge.
    int         cyc = 0, done_cnt = 0, ferr_cnt = 0, perr_cnt = 0, busy_cyc = 0, last_done_cyc = 0;
    logic [7:0] got_q[$];
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.rx_done === 1'b1) begin
            done_cnt = done_cnt + 1;
            got_q.push_back(bus.rx_data);
            last_done_cyc = cyc;
        end
        if (bus.frame_err === 1'b1)  ferr_cnt = ferr_cnt + 1;
        if (bus.parity_err === 1'b1) perr_cnt = perr_cnt + 1;
        if (bus.rx_busy === 1'b1)    busy_cyc = busy_cyc + 1;
    end

    // Frame-level reference model state.
    int         n_cmp = 0, n_bad = 0;
    int         exp_done = 0, exp_ferr = 0, exp_perr = 0, rd_idx = 0, start_cyc = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_good = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input int clks);
        bus.rx = b;
        repeat (clks) @(negedge clk);
    endtask

    // A bad stop bit is held low only past its midpoint so the receiver's re-entry ends as a false start.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic par_ok);
        start_cyc = cyc;
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ ~par_ok, BIT_CLKS);
`endif
        if (stop_ok) begin
            drive_bit(1'b1, BIT_CLKS);
        end else begin
            drive_bit(1'b0, 40);
            drive_bit(1'b1, BIT_CLKS - 40);
        end
        if (stop_ok && par_ok) begin
            exp_q.push_back(d);
            last_good = d;
            exp_done++;
        end
        if (!stop_ok) exp_ferr++;
        if (!par_ok)  exp_perr++;
    endtask

    task automatic checkpoint(input string tag);
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'(exp_done));
        check({tag, "_ferr_cnt"}, 32'(ferr_cnt), 32'(exp_ferr));
        check({tag, "_perr_cnt"}, 32'(perr_cnt), 32'(exp_perr));
        check({tag, "_rx_data"},  32'(bus.rx_data), 32'(last_good));
        check({tag, "_busy"},     32'(bus.rx_busy), 32'(0));
        check({tag, "_nbytes"},   32'(got_q.size()), 32'(exp_q.size()));
        while (rd_idx < exp_q.size() && rd_idx < got_q.size()) begin
            check({tag, "_byte"}, 32'(got_q[rd_idx]), 32'(exp_q[rd_idx]));
            rd_idx++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_data"}, 32'(bus.rx_data), 32'(0));
        check({tag, "_done"},    32'(bus.rx_done), 32'(0));
        check({tag, "_busy"},    32'(bus.rx_busy), 32'(0));
        check({tag, "_ferr"},    32'(bus.frame_err), 32'(0));
        check({tag, "_perr"},    32'(bus.parity_err), 32'(0));
    endtask

    initial begin
        int   b0;
        int   lat;
        logic sok, pok;
        logic [7:0] d;
        bus.rx = 1'b1;
        repeat (4) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        drive_bit(1'b1, BIT_CLKS);

        // Single good frame, with latency window.
        send_frame(8'hA5, 1'b1, 1'b1);
        lat = last_done_cyc - start_cyc;
        check("latency_in_window", 32'((lat >= LAT_NOM - 4) && (lat <= LAT_NOM + 6)), 32'(1));
        drive_bit(1'b1, BIT_CLKS);
        checkpoint("a5");

        // Short glitch: false start only.
        b0 = busy_cyc;
        drive_bit(1'b0, 4 * TICK_DIV);
        drive_bit(1'b1, 2 * BIT_CLKS);
        check("glitch_busy_pulse", 32'(busy_cyc > b0), 32'(1));
        checkpoint("glitch");

        // Framing error after a good byte.
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b1);
        drive_bit(1'b1, BIT_CLKS);
        checkpoint("ferr");

        // Back-to-back frames, no idle.
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        send_frame(8'h55, 1'b1, 1'b1);
        drive_bit(1'b1, BIT_CLKS);
        checkpoint("b2b");

        // Reset mid-frame after bit 3 of 0xC3.
        d = 8'hC3;
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) drive_bit(d[i], BIT_CLKS);
        reset  = 1'b1;
        bus.rx = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        reset = 1'b0;
        last_good = 8'h00;
        drive_bit(1'b1, 2 * BIT_CLKS);
        send_frame(8'h7E, 1'b1, 1'b1);
        drive_bit(1'b1, BIT_CLKS);
        checkpoint("after_reset");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h01, 1'b1, 1'b1);
        drive_bit(1'b1, BIT_CLKS);
        checkpoint("par_good");
        send_frame(8'h01, 1'b1, 1'b0);
        drive_bit(1'b1, BIT_CLKS);
        checkpoint("par_bad");
`endif

        // Randomized frames with occasional stop/parity faults.
        for (int n = 0; n < 10; n++) begin
            d   = 8'($urandom);
            sok = ($urandom_range(0, 4) != 0);
`ifdef UART_RX_PARITY_EN
            pok = ($urandom_range(0, 3) != 0);
`else
            pok = 1'b1;
`endif
            send_frame(d, sok, pok);
            drive_bit(1'b1, BIT_CLKS);
        end
        checkpoint("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
